// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - extracts 55 AA LEN PAYLOAD [CHK] frames from the UART RX byte stream
// Define UART_FRAME_CHK_EN to require and verify the trailing checksum byte.
module uart_frame_parser #(
   parameter int P_MAX_LEN = 16,
   parameter int P_TIMEOUT = 100000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_last,
   output logic       o_frame_ok,
   output logic       o_frame_err,
   output logic [1:0] o_err_code,
   output logic       o_drop,
   output logic       o_busy
);
   localparam int LW = $clog2(P_MAX_LEN + 1);
   localparam int AW = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
   localparam int TW = $clog2(P_TIMEOUT + 1);
   localparam logic [7:0]    MAX_LEN8 = 8'(P_MAX_LEN);
   localparam logic [TW-1:0] TMO_LAST = TW'(P_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR2, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] idx_q, idx_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          frame_ok_q, frame_ok_d;
   logic          frame_err_q, frame_err_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          wr_en;
   logic          idx_at_end;
   logic          in_frame;
   logic [7:0]    buf_q [P_MAX_LEN];
`ifdef UART_FRAME_CHK_EN
   logic [7:0]    sum_q, sum_d;
`endif

   // idx_q is the write pointer while collecting and the read pointer while draining
   assign idx_at_end = (idx_q == len_q - LW'(1));
   assign in_frame   = (state_q == S_HDR2) || (state_q == S_LEN) ||
                       (state_q == S_PAYLOAD) || (state_q == S_CHK);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      tmo_d       = '0;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      wr_en       = 1'b0;
`ifdef UART_FRAME_CHK_EN
      sum_d       = sum_q;
`endif
      if (!i_rx_valid && in_frame) tmo_d = tmo_q + TW'(1);

      case (state_q)
         S_IDLE: if (i_rx_valid && i_rx_data == 8'h55) state_d = S_HDR2;
         S_HDR2: if (i_rx_valid) begin
            if (i_rx_data == 8'hAA)      state_d = S_LEN;
            else if (i_rx_data != 8'h55) state_d = S_IDLE;
         end
         S_LEN: if (i_rx_valid) begin
            if (i_rx_data == 8'h00 || i_rx_data > MAX_LEN8) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
               err_code_d  = 2'd1;
            end else begin
               state_d = S_PAYLOAD;
               len_d   = i_rx_data[LW-1:0];
               idx_d   = '0;
`ifdef UART_FRAME_CHK_EN
               sum_d   = i_rx_data;
`endif
            end
         end
         S_PAYLOAD: if (i_rx_valid) begin
            wr_en = 1'b1;
            idx_d = idx_q + LW'(1);
`ifdef UART_FRAME_CHK_EN
            sum_d = sum_q + i_rx_data;
            if (idx_at_end) state_d = S_CHK;
`else
            if (idx_at_end) begin
               state_d    = S_DRAIN;
               frame_ok_d = 1'b1;
               idx_d      = '0;
            end
`endif
         end
`ifdef UART_FRAME_CHK_EN
         S_CHK: if (i_rx_valid) begin
            if (i_rx_data == sum_q) begin
               state_d    = S_DRAIN;
               frame_ok_d = 1'b1;
               idx_d      = '0;
            end else begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
               err_code_d  = 2'd2;
            end
         end
`endif
         S_DRAIN: if (i_ready) begin
            if (idx_at_end) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + LW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A stalled sender aborts the frame; an arriving byte always wins over the timeout
      if (!i_rx_valid && in_frame && tmo_q == TMO_LAST) begin
         state_d     = S_IDLE;
         frame_err_d = 1'b1;
         err_code_d  = 2'd3;
         tmo_d       = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         tmo_q       <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= 2'd0;
`ifdef UART_FRAME_CHK_EN
         sum_q       <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
`ifdef UART_FRAME_CHK_EN
         sum_q       <= sum_d;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) buf_q[idx_q[AW-1:0]] <= i_rx_data;
   end

   assign o_valid     = (state_q == S_DRAIN);
   assign o_data      = o_valid ? buf_q[idx_q[AW-1:0]] : 8'h00;
   assign o_last      = o_valid && idx_at_end;
   assign o_frame_ok  = frame_ok_q;
   assign o_frame_err = frame_err_q;
   assign o_err_code  = err_code_q;
   assign o_drop      = o_valid && i_rx_valid;
   assign o_busy      = (state_q != S_IDLE);
endmodule
